uart_tx_sched: RTL

// Round-robin scheduler that shares one uart_tx transmitter among NUM_REQ byte requesters.

---
 rtl/uart_tx_sched_pkg.sv | 27 ++
 rtl/uart_tx_sched_if.sv | 23 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 30 +++
 rtl/uart_tx_sched.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx request scheduler.
package uart_tx_sched_pkg;

  localparam int unsigned LEN_MIN = 5;
  localparam int unsigned LEN_MAX = 8;
  localparam int unsigned CFG_W   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CFGERR,
    ST_GAP
  } sched_state_t;

  typedef struct packed {
    logic       stop2;
    logic       parity_en;
    logic       parity_type;
    logic [3:0] length;
  } uart_cfg_t;

  function automatic logic len_ok(input logic [3:0] len);
    return (32'(len) >= LEN_MIN) && (32'(len) <= LEN_MAX);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side bundle: per-requester byte, frame config, handshake and completion.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import uart_tx_sched_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*8-1:0]     req_data;
  logic [NUM_REQ*CFG_W-1:0] req_cfg;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       frame_done;

  modport master (
    output req_valid, req_data, req_cfg,
    input  req_ready, frame_done
  );

  modport slave (
    input  req_valid, req_data, req_cfg,
    output req_ready, frame_done
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first valid index strictly after ptr, wrapping.
module uart_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [IDW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos = IDW'((32'(ptr) + k) % NUM_REQ);
      if (!any && valid[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among NUM_REQ requesters: round-robin grant, config check,
// start pulse, hold-until-done and a watchdog that aborts stuck frames.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                       tx_clk,
  input  logic                       rst_n,
  uart_tx_sched_if.slave             req,
  output logic                       uart_start,
  output logic [7:0]                 uart_data,
  output logic [3:0]                 uart_length,
  output logic                       uart_parity_type,
  output logic                       uart_parity_en,
  output logic                       uart_stop2,
  input  logic                       uart_done,
  output logic                       uart_abort,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       cfg_err,
  output logic                       timeout_err,
  output logic                       err_sticky,
  input  logic                       err_clr
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);

  sched_state_t       state, state_n;
  logic [IDW-1:0]     ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_onehot, done_vec;
  logic               pick_any, done_hit, expire;
  logic [WDW-1:0]     wd_cnt;
  logic [GW-1:0]      gap_cnt;
  uart_cfg_t          sel_cfg;
  logic [7:0]         sel_data;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .valid (req.req_valid),
    .ptr   (ptr),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_data = req.req_data[32'(pick_idx)*8 +: 8];
  assign sel_cfg  = uart_cfg_t'(req.req_cfg[32'(pick_idx)*CFG_W +: CFG_W]);
  assign done_hit = (state == ST_WAIT) && uart_done;
  assign expire   = (state == ST_WAIT) && !uart_done && (wd_cnt == WDW'(TIMEOUT - 1));

  // Handshake and completion strobes are same-cycle; held off while reset is asserted.
  assign req.req_ready  = (rst_n && state == ST_IDLE) ? pick_onehot : '0;
  assign req.frame_done = done_vec;
  assign timeout_err    = rst_n && expire;
  assign uart_abort     = rst_n && expire;

  always_comb begin
    done_vec = '0;
    if (rst_n && done_hit) done_vec[grant_id] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (pick_any) state_n = len_ok(sel_cfg.length) ? ST_LAUNCH : ST_CFGERR;
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT:   if (uart_done || expire) state_n = ST_GAP;
      ST_CFGERR: state_n = ST_GAP;
      ST_GAP:    if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      ptr              <= IDW'(NUM_REQ - 1);
      grant_id         <= '0;
      uart_start       <= 1'b0;
      uart_data        <= '0;
      uart_length      <= '0;
      uart_parity_type <= 1'b0;
      uart_parity_en   <= 1'b0;
      uart_stop2       <= 1'b0;
      busy             <= 1'b0;
      cfg_err          <= 1'b0;
      err_sticky       <= 1'b0;
      wd_cnt           <= '0;
      gap_cnt          <= '0;
    end else begin
      uart_start <= (state_n == ST_LAUNCH);
      cfg_err    <= (state_n == ST_CFGERR);
      busy       <= (state_n != ST_IDLE);
      wd_cnt     <= (state == ST_WAIT) ? wd_cnt + WDW'(1) : '0;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == ST_IDLE && pick_any) begin
        grant_id <= pick_idx;
        ptr      <= pick_idx;
        if (state_n == ST_LAUNCH) begin
          uart_data        <= sel_data;
          uart_length      <= sel_cfg.length;
          uart_parity_type <= sel_cfg.parity_type;
          uart_parity_en   <= sel_cfg.parity_en;
          uart_stop2       <= sel_cfg.stop2;
        end
      end
      if (cfg_err || expire) err_sticky <= 1'b1;
      else if (err_clr)      err_sticky <= 1'b0;
    end
  end

endmodule
